block_store_arbiter: RTL

- Owns the block-alive bitmap for the playfield and shares its single access port between two requesters.
- Requester one is the renderer pixel path, a read-only port with highest priority.
- Requester two is the game-logic collision engine, which reads, kills and revives blocks through a req/ack handshake.
- Also sequences level refill and tracks the alive count, pulsing when the level is cleared.

---
 rtl/block_store_pkg.sv | 19 +
 rtl/block_alive_store.sv | 29 ++
 rtl/block_store_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/block_store_pkg.sv
// Shared definitions for the block store: playfield geometry, logic-port op codes, arbiter states.
package block_store_pkg;

  localparam int PLAYFIELD_COLS = 10;
  localparam int PLAYFIELD_ROWS = 10;
  localparam int NUM_BLOCKS_DEF = PLAYFIELD_COLS * PLAYFIELD_ROWS;
  localparam int ADDR_W_DEF     = $clog2(NUM_BLOCKS_DEF);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_KILL   = 2'b01;
  localparam logic [1:0] OP_REVIVE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FILL   = 2'd2
  } state_t;

endpackage

// File: rtl/block_alive_store.sv
// Block-alive bitmap with one combinational read / synchronous write port.
// Addresses at or beyond NUM_BLOCKS read as dead and ignore writes.
module block_alive_store #(
  parameter int NUM_BLOCKS = 100,
  parameter int ADDR_W     = 7
) (
  input  logic              CLK,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              wdata,
  output logic              rd_bit,
  output logic              in_range
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);

  logic [NUM_BLOCKS-1:0] bits_q;

  assign in_range = (addr <= LAST_ADDR);
  assign rd_bit   = in_range && bits_q[addr];

  // Contents are deliberately unreset; the arbiter refills them after reset.
  always_ff @(posedge CLK) begin
    if (we && in_range) begin
      bits_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/block_store_arbiter.sv
// Arbitrates the block bitmap between the renderer (priority) and the collision engine,
// sequences level refill and tracks the alive count. Optional BLOCK_STORE_STARVE_GUARD_EN
// lets a logic request that has waited MAX_WAIT cycles steal one cycle from the renderer.
module block_store_arbiter
  import block_store_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int CNT_W      = 7,
  parameter int MAX_WAIT   = 1056
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RENDER_EN,
  input  logic [ADDR_W-1:0] RENDER_ADDR,
  output logic              RENDER_ALIVE,
  input  logic              LOGIC_REQ,
  input  logic [1:0]        LOGIC_OP,
  input  logic [ADDR_W-1:0] LOGIC_ADDR,
  output logic              LOGIC_ACK,
  output logic              LOGIC_ALIVE,
  input  logic              LEVEL_RESET_REQ,
  output logic              BUSY,
  output logic [CNT_W-1:0]  ALIVE_COUNT,
  output logic              LEVEL_CLEAR
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic [1:0]        op_q;
  logic              rng_q;

  logic [ADDR_W-1:0] st_addr;
  logic              st_we, st_wdata, st_bit, st_rng;
  logic              grant_logic, serve_render, starve_fire;

  block_alive_store #(
    .NUM_BLOCKS(NUM_BLOCKS),
    .ADDR_W    (ADDR_W)
  ) u_store (
    .CLK     (CLK),
    .addr    (st_addr),
    .we      (st_we),
    .wdata   (st_wdata),
    .rd_bit  (st_bit),
    .in_range(st_rng)
  );

`ifdef BLOCK_STORE_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q;

  assign starve_fire = (wait_q == WAIT_LIMIT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_q <= '0;
    end else if (!LOGIC_REQ || grant_logic) begin
      wait_q <= '0;
    end else if (state_q == IDLE && !starve_fire) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`else
  // Guard compiled out: the renderer always wins while RENDER_EN is high.
  assign starve_fire = (MAX_WAIT < 0);
`endif

  always_comb begin
    state_d      = state_q;
    st_addr      = RENDER_ADDR;
    st_we        = 1'b0;
    st_wdata     = 1'b0;
    grant_logic  = 1'b0;
    serve_render = 1'b0;
    unique case (state_q)
      FILL: begin
        st_addr  = ptr_q;
        st_we    = 1'b1;
        st_wdata = 1'b1;
        if (ptr_q == LAST_ADDR) state_d = IDLE;
      end
      ACCESS: begin
        st_addr = op_addr_q;
        state_d = IDLE;
        case (op_q)
          OP_KILL: begin
            st_we    = 1'b1;
            st_wdata = 1'b0;
          end
          OP_REVIVE: begin
            st_we    = 1'b1;
            st_wdata = 1'b1;
          end
          OP_READ, 2'b11: ;
          default: ;
        endcase
      end
      default: begin
        if (LEVEL_RESET_REQ) begin
          state_d = FILL;
        end else if (LOGIC_REQ && (starve_fire || !RENDER_EN)) begin
          // The old bit is read here so ACK and LOGIC_ALIVE can appear together in ACCESS.
          grant_logic = 1'b1;
          st_addr     = LOGIC_ADDR;
          state_d     = ACCESS;
        end else if (RENDER_EN) begin
          serve_render = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= FILL;
      ptr_q        <= '0;
      RENDER_ALIVE <= 1'b0;
      LOGIC_ACK    <= 1'b0;
      LOGIC_ALIVE  <= 1'b0;
      BUSY         <= 1'b0;
      ALIVE_COUNT  <= '0;
      LEVEL_CLEAR  <= 1'b0;
    end else begin
      state_q     <= state_d;
      BUSY        <= (state_d == FILL);
      LOGIC_ACK   <= grant_logic;
      LEVEL_CLEAR <= 1'b0;
      if (grant_logic) LOGIC_ALIVE <= st_bit;

      if (state_q == FILL) begin
        RENDER_ALIVE <= 1'b0;
      end else if (serve_render) begin
        RENDER_ALIVE <= st_bit;
      end

      if (state_q == FILL) begin
        if (ptr_q == LAST_ADDR) begin
          ptr_q       <= '0;
          ALIVE_COUNT <= CNT_W'(NUM_BLOCKS);
        end else begin
          ptr_q <= ptr_q + 1'b1;
        end
      end

      // LOGIC_ALIVE still holds the pre-op bit during ACCESS.
      if (state_q == ACCESS) begin
        if (op_q == OP_KILL && LOGIC_ALIVE) begin
          ALIVE_COUNT <= ALIVE_COUNT - 1'b1;
          if (ALIVE_COUNT == CNT_W'(1)) LEVEL_CLEAR <= 1'b1;
        end else if (op_q == OP_REVIVE && !LOGIC_ALIVE && rng_q) begin
          ALIVE_COUNT <= ALIVE_COUNT + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (grant_logic) begin
      op_addr_q <= LOGIC_ADDR;
      op_q      <= LOGIC_OP;
      rng_q     <= st_rng;
    end
  end

endmodule
